// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP TX path between NUM_SRC sources.
// A source is granted for a whole packet: from header acceptance through the
// payload tlast handshake. Header and payload pass through combinationally.
module udp_tx_arbiter #(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned AXI_DATA_WIDTH = 8
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic [NUM_SRC-1:0]                  s_udp_hdr_tvalid,
    output logic [NUM_SRC-1:0]                  s_udp_hdr_trdy,
    input  logic [NUM_SRC*16-1:0]               s_udp_src_port,
    input  logic [NUM_SRC*16-1:0]               s_udp_dst_port,
    input  logic [NUM_SRC*16-1:0]               s_udp_length_port,
    input  logic [NUM_SRC*16-1:0]               s_udp_hdr_checksum,
    input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]                  s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                  s_axis_tlast,
    output logic [NUM_SRC-1:0]                  s_axis_trdy,
    output logic                                m_udp_hdr_tvalid,
    input  logic                                m_udp_hdr_trdy,
    output logic [15:0]                         m_udp_src_port,
    output logic [15:0]                         m_udp_dst_port,
    output logic [15:0]                         m_udp_length_port,
    output logic [15:0]                         m_udp_hdr_checksum,
    output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_trdy,
    output logic [NUM_SRC-1:0]                  o_grant
);

    localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_e;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]      gidx_q, gidx_d;
    logic [IdxW-1:0]      last_q, last_d;

    // Signals of the currently granted source
    logic                      g_hdr_valid;
    logic                      g_axis_valid;
    logic                      g_axis_last;
    logic [15:0]               g_src, g_dst, g_len, g_csum;
    logic [AXI_DATA_WIDTH-1:0] g_data;

    logic                      found;
    logic [IdxW-1:0]           sel;

    // Select the granted source's header and payload signals
    always_comb begin
        g_hdr_valid  = 1'b0;
        g_axis_valid = 1'b0;
        g_axis_last  = 1'b0;
        g_src        = '0;
        g_dst        = '0;
        g_len        = '0;
        g_csum       = '0;
        g_data       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gidx_q == IdxW'(i)) begin
                g_hdr_valid  = s_udp_hdr_tvalid[i];
                g_axis_valid = s_axis_tvalid[i];
                g_axis_last  = s_axis_tlast[i];
                g_src        = s_udp_src_port[i*16 +: 16];
                g_dst        = s_udp_dst_port[i*16 +: 16];
                g_len        = s_udp_length_port[i*16 +: 16];
                g_csum       = s_udp_hdr_checksum[i*16 +: 16];
                g_data       = s_axis_tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

    // Round-robin pick: first requester above last_q, else wrap to the lowest index
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && (IdxW'(i) > last_q) && s_udp_hdr_tvalid[i]) begin
                found = 1'b1;
                sel   = IdxW'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && (IdxW'(i) <= last_q) && s_udp_hdr_tvalid[i]) begin
                found = 1'b1;
                sel   = IdxW'(i);
            end
        end
    end

    // State and grant registers; reset aborts any packet in flight
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IdxW'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant in IDLE, hold through header and payload until tlast
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StHdr;
                    grant_d = NUM_SRC'(1) << sel;
                    gidx_d  = sel;
                end
            end
            StHdr: begin
                if (g_hdr_valid && m_udp_hdr_trdy) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (g_axis_valid && m_axis_trdy && g_axis_last) begin
                    state_d = StIdle;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: only the active phase of the granted source is connected
    always_comb begin
        m_udp_hdr_tvalid   = 1'b0;
        m_udp_src_port     = '0;
        m_udp_dst_port     = '0;
        m_udp_length_port  = '0;
        m_udp_hdr_checksum = '0;
        m_axis_tdata       = '0;
        m_axis_tvalid      = 1'b0;
        m_axis_tlast       = 1'b0;
        s_udp_hdr_trdy     = '0;
        s_axis_trdy        = '0;
        unique case (state_q)
            StHdr: begin
                m_udp_hdr_tvalid   = g_hdr_valid;
                m_udp_src_port     = g_src;
                m_udp_dst_port     = g_dst;
                m_udp_length_port  = g_len;
                m_udp_hdr_checksum = g_csum;
                s_udp_hdr_trdy     = grant_q & {NUM_SRC{m_udp_hdr_trdy}};
            end
            StPayload: begin
                m_axis_tdata  = g_data;
                m_axis_tvalid = g_axis_valid;
                m_axis_tlast  = g_axis_last;
                s_axis_trdy   = grant_q & {NUM_SRC{m_axis_trdy}};
            end
            default: ;
        endcase
    end

    assign o_grant = grant_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter against a packet-level reference model.
module tb_udp_tx_arbiter;

    localparam int NS   = 2;
    localparam int DW   = 8;
    localparam int NPKT = 12;

    logic              i_clk;
    logic              i_reset_n;
    logic [NS-1:0]     s_udp_hdr_tvalid;
    logic [NS-1:0]     s_udp_hdr_trdy;
    logic [NS*16-1:0]  s_udp_src_port;
    logic [NS*16-1:0]  s_udp_dst_port;
    logic [NS*16-1:0]  s_udp_length_port;
    logic [NS*16-1:0]  s_udp_hdr_checksum;
    logic [NS*DW-1:0]  s_axis_tdata;
    logic [NS-1:0]     s_axis_tvalid;
    logic [NS-1:0]     s_axis_tlast;
    logic [NS-1:0]     s_axis_trdy;
    logic              m_udp_hdr_tvalid;
    logic              m_udp_hdr_trdy;
    logic [15:0]       m_udp_src_port;
    logic [15:0]       m_udp_dst_port;
    logic [15:0]       m_udp_length_port;
    logic [15:0]       m_udp_hdr_checksum;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_trdy;
    logic [NS-1:0]     o_grant;

    udp_tx_arbiter #(
        .NUM_SRC        (NS),
        .AXI_DATA_WIDTH (DW)
    ) u_dut (
        .i_clk              (i_clk),
        .i_reset_n          (i_reset_n),
        .s_udp_hdr_tvalid   (s_udp_hdr_tvalid),
        .s_udp_hdr_trdy     (s_udp_hdr_trdy),
        .s_udp_src_port     (s_udp_src_port),
        .s_udp_dst_port     (s_udp_dst_port),
        .s_udp_length_port  (s_udp_length_port),
        .s_udp_hdr_checksum (s_udp_hdr_checksum),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_trdy        (s_axis_trdy),
        .m_udp_hdr_tvalid   (m_udp_hdr_tvalid),
        .m_udp_hdr_trdy     (m_udp_hdr_trdy),
        .m_udp_src_port     (m_udp_src_port),
        .m_udp_dst_port     (m_udp_dst_port),
        .m_udp_length_port  (m_udp_length_port),
        .m_udp_hdr_checksum (m_udp_hdr_checksum),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_trdy        (m_axis_trdy),
        .o_grant            (o_grant)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Packet store: header packed as {src, dst, len, csum}
    logic [63:0] pkt_hdr  [NS][NPKT];
    int          pkt_len  [NS][NPKT];
    logic [7:0]  pkt_data [NS][NPKT][8];
    int          npk      [NS];

    // Source driver state
    int drv_p [NS];
    int drv_b [NS];
    bit hdr_on   [NS];
    bit hdr_done [NS];
    bit av       [NS];
    bit f_hdr    [NS];
    bit f_ax     [NS];
    bit force_rdy;

    // Reference model: one packet owner at a time, round-robin from last owner
    bit m_busy;
    bit m_hdone;
    int m_g;
    int m_last;
    int mon_p [NS];
    int mon_b [NS];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic gen_pkt(input int s, input int p, input int len);
        pkt_len[s][p] = len;
        pkt_hdr[s][p] = {$urandom, $urandom};
        for (int b = 0; b < 8; b++) pkt_data[s][p][b] = 8'($urandom);
    endtask

    task automatic clear_state();
        for (int s = 0; s < NS; s++) begin
            drv_p[s] = 0; drv_b[s] = 0; hdr_on[s] = 0; hdr_done[s] = 0; av[s] = 0;
            f_hdr[s] = 0; f_ax[s] = 0; mon_p[s] = 0; mon_b[s] = 0; npk[s] = 0;
        end
        m_busy = 0; m_hdone = 0; m_g = 0; m_last = NS - 1;
        s_udp_hdr_tvalid = '0; s_udp_src_port = '0; s_udp_dst_port = '0;
        s_udp_length_port = '0; s_udp_hdr_checksum = '0;
        s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
        m_udp_hdr_trdy = 1'b0; m_axis_trdy = 1'b0;
    endtask

    function automatic bit all_done();
        bit d = 1;
        for (int s = 0; s < NS; s++) if (mon_p[s] != npk[s]) d = 0;
        return d;
    endfunction

    // One clock: drive on the falling edge, sample and model just before the rising edge
    task automatic step();
        logic [NS-1:0] req;
        bit            found;
        int            idx;
        int            p;
        @(negedge i_clk);
        for (int s = 0; s < NS; s++) begin
            if (f_hdr[s]) begin hdr_on[s] = 0; hdr_done[s] = 1; end
            if (f_ax[s]) begin
                av[s] = 0;
                if (drv_b[s] == pkt_len[s][drv_p[s]] - 1) begin
                    drv_p[s]++; drv_b[s] = 0; hdr_done[s] = 0;
                end else begin
                    drv_b[s]++;
                end
            end
            if (drv_p[s] < npk[s]) begin
                if (!hdr_on[s] && !hdr_done[s] && $urandom_range(2) != 0) hdr_on[s] = 1;
                // Payload may be offered before the header is accepted
                if ((hdr_on[s] || hdr_done[s]) && !av[s]) av[s] = ($urandom_range(3) != 0);
                s_udp_hdr_tvalid[s] = hdr_on[s];
                {s_udp_src_port[s*16 +: 16], s_udp_dst_port[s*16 +: 16],
                 s_udp_length_port[s*16 +: 16], s_udp_hdr_checksum[s*16 +: 16]}
                    = pkt_hdr[s][drv_p[s]];
                s_axis_tvalid[s] = av[s];
                s_axis_tdata[s*DW +: DW] = pkt_data[s][drv_p[s]][drv_b[s]];
                s_axis_tlast[s] = (drv_b[s] == pkt_len[s][drv_p[s]] - 1);
            end else begin
                s_udp_hdr_tvalid[s] = 1'b0;
                s_axis_tvalid[s] = 1'b0;
                s_axis_tlast[s] = 1'b0;
            end
        end
        m_udp_hdr_trdy = force_rdy ? 1'b1 : ($urandom_range(2) != 0);
        m_axis_trdy    = force_rdy ? 1'b1 : ($urandom_range(2) != 0);
        #4;
        for (int s = 0; s < NS; s++) begin
            f_hdr[s] = s_udp_hdr_tvalid[s] & s_udp_hdr_trdy[s];
            f_ax[s]  = s_axis_tvalid[s] & s_axis_trdy[s];
        end
        check_eq("grant", 64'(o_grant), m_busy ? (64'(1) << m_g) : 64'(0));
        check_eq("m_hdr_tvalid", 64'(m_udp_hdr_tvalid),
                 64'(m_busy && !m_hdone && ((s_udp_hdr_tvalid >> m_g) & 1) != 0));
        check_eq("s_hdr_trdy", 64'(s_udp_hdr_trdy),
                 (m_busy && !m_hdone && m_udp_hdr_trdy) ? (64'(1) << m_g) : 64'(0));
        check_eq("s_axis_trdy", 64'(s_axis_trdy),
                 (m_busy && m_hdone && m_axis_trdy) ? (64'(1) << m_g) : 64'(0));
        check_eq("m_axis_tvalid", 64'(m_axis_tvalid),
                 64'(m_busy && m_hdone && ((s_axis_tvalid >> m_g) & 1) != 0));
        check_eq("m_axis_tlast", 64'(m_axis_tlast),
                 64'(m_busy && m_hdone && ((s_axis_tlast >> m_g) & 1) != 0));
        if (m_busy) begin
            p = mon_p[m_g];
            if (m_udp_hdr_tvalid && m_udp_hdr_trdy) begin
                if (p < npk[m_g]) begin
                    check_eq("hdr_fields", {m_udp_src_port, m_udp_dst_port,
                             m_udp_length_port, m_udp_hdr_checksum}, pkt_hdr[m_g][p]);
                end
                m_hdone = 1;
            end
            if (m_axis_tvalid && m_axis_trdy && p < npk[m_g]) begin
                check_eq("beat_data", 64'(m_axis_tdata), 64'(pkt_data[m_g][p][mon_b[m_g]]));
                check_eq("beat_last", 64'(m_axis_tlast),
                         64'(mon_b[m_g] == pkt_len[m_g][p] - 1));
                if (mon_b[m_g] == pkt_len[m_g][p] - 1) begin
                    mon_p[m_g]++; mon_b[m_g] = 0;
                    m_busy = 0; m_hdone = 0; m_last = m_g;
                end else begin
                    mon_b[m_g]++;
                end
            end
        end else begin
            req = s_udp_hdr_tvalid;
            found = 0;
            for (int k = 1; k <= NS; k++) begin
                idx = (m_last + k) % NS;
                if (!found && ((req >> idx) & 1) != 0) begin
                    found = 1; m_g = idx; m_busy = 1; m_hdone = 0;
                end
            end
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        force_rdy = 0;
        clear_state();
        // Requests and readies present during reset must not leak through
        s_udp_hdr_tvalid = '1; s_axis_tvalid = '1; s_axis_tlast = '1;
        m_udp_hdr_trdy = 1'b1; m_axis_trdy = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        check_eq("rst_grant", 64'(o_grant), 64'(0));
        check_eq("rst_m_hdr_tvalid", 64'(m_udp_hdr_tvalid), 64'(0));
        check_eq("rst_m_axis_tvalid", 64'(m_axis_tvalid), 64'(0));
        check_eq("rst_m_axis_tlast", 64'(m_axis_tlast), 64'(0));
        check_eq("rst_s_hdr_trdy", 64'(s_udp_hdr_trdy), 64'(0));
        check_eq("rst_s_axis_trdy", 64'(s_axis_trdy), 64'(0));
        clear_state();
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Random traffic; source 0 opens with a fixed 4-beat packet
        for (int s = 0; s < NS; s++) begin
            npk[s] = NPKT;
            for (int p = 0; p < NPKT; p++) gen_pkt(s, p, 1 + int'($urandom_range(5)));
        end
        pkt_hdr[0][0] = {16'h1234, 16'h0050, 16'd12, 16'hABCD};
        pkt_len[0][0] = 4;
        for (int b = 0; b < 4; b++) pkt_data[0][0][b] = 8'(b + 1);
        for (int c = 0; c < 5000 && !all_done(); c++) step();
        check_eq("random_all_done", 64'(all_done()), 64'(1));
        repeat (3) step();

        // Reset in the middle of an 8-beat packet
        clear_state();
        force_rdy = 1;
        npk[0] = 1;
        gen_pkt(0, 0, 8);
        for (int c = 0; c < 100 && mon_b[0] < 3; c++) step();
        check_eq("reach_beat3", 64'(mon_b[0]), 64'(3));
        @(negedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_eq("arst_grant", 64'(o_grant), 64'(0));
        check_eq("arst_m_hdr_tvalid", 64'(m_udp_hdr_tvalid), 64'(0));
        check_eq("arst_m_axis_tvalid", 64'(m_axis_tvalid), 64'(0));
        check_eq("arst_m_axis_tlast", 64'(m_axis_tlast), 64'(0));
        check_eq("arst_s_hdr_trdy", 64'(s_udp_hdr_trdy), 64'(0));
        check_eq("arst_s_axis_trdy", 64'(s_axis_trdy), 64'(0));
        clear_state();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        npk[1] = 1;
        gen_pkt(1, 0, 3);
        for (int c = 0; c < 100 && !all_done(); c++) step();
        check_eq("post_rst_src1_done", 64'(mon_p[1]), 64'(1));
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
